mem_port_arbiter: RTL and testbench

- Shares one single-port `memory` instance between two requesters: port A (instruction fetch, read-only) and port B (data load/store).
- Sits between the fetch/LSU stages and the unified memory.
- Performs round-robin arbitration, applies write enables, and returns read data tagged to the correct requester, honouring the memory's one-cycle registered-address read latency.
- Holds off all traffic for a fixed window after reset while the memory loads its init file.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// The arbiter takes the slave view; the environment takes the master view.
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

interface mem_port_arbiter_if;
   logic              a_req;
   logic [`ISIZE-1:0] a_addr;
   logic              a_gnt;
   logic              a_rvalid;
   logic [`DSIZE-1:0] a_rdata;

   logic              b_req;
   logic              b_wen;
   logic [`ISIZE-1:0] b_addr;
   logic [`DSIZE-1:0] b_wdata;
   logic              b_gnt;
   logic              b_rvalid;
   logic [`DSIZE-1:0] b_rdata;

   logic              mem_wen;
   logic [`ISIZE-1:0] mem_addr;
   logic [`DSIZE-1:0] mem_wdata;
   logic [`DSIZE-1:0] mem_rdata;

   modport slave (
      input  a_req, a_addr,
      input  b_req, b_wen, b_addr, b_wdata,
      input  mem_rdata,
      output a_gnt, a_rvalid, a_rdata,
      output b_gnt, b_rvalid, b_rdata,
      output mem_wen, mem_addr, mem_wdata
   );

   modport master (
      output a_req, a_addr,
      output b_req, b_wen, b_addr, b_wdata,
      output mem_rdata,
      input  a_gnt, a_rvalid, a_rdata,
      input  b_gnt, b_rvalid, b_rdata,
      input  mem_wen, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (A)
// and load/store (B), with a post-reset hold-off window.
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

module mem_port_arbiter #(
   parameter int INIT_CYCLES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   mem_port_arbiter_if.slave bus,
   output logic             ready,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [INIT_W-1:0] INIT_LAST =
      INIT_W'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   // A zero-length window skips INIT so the first grant follows reset directly.
   localparam state_t RST_STATE = (INIT_CYCLES == 0) ? S_RUN : S_INIT;

   state_t            state;
   state_t            state_nx;
   logic [INIT_W-1:0] init_cnt;
   logic [INIT_W-1:0] init_cnt_nx;
   logic              prio;
   logic              prio_nx;
   logic              a_gnt;
   logic              b_gnt;
   logic              conflict;
   logic              a_rv_q;
   logic              b_rv_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RST_STATE;
         init_cnt     <= '0;
         prio         <= 1'b0;
         a_rv_q       <= 1'b0;
         b_rv_q       <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         state    <= state_nx;
         init_cnt <= init_cnt_nx;
         prio     <= prio_nx;
         a_rv_q   <= a_gnt;
         b_rv_q   <= b_gnt && !bus.b_wen;
         if (conflict && !(&conflict_cnt))
            conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nx    = state;
      init_cnt_nx = init_cnt;
      prio_nx     = prio;
      a_gnt       = 1'b0;
      b_gnt       = 1'b0;
      conflict    = 1'b0;
      ready       = 1'b0;
      unique case (state)
         S_INIT: begin
            init_cnt_nx = init_cnt + 1'b1;
            if (init_cnt == INIT_LAST) begin
               state_nx    = S_RUN;
               init_cnt_nx = '0;
            end
         end
         S_RUN: begin
            ready    = 1'b1;
            conflict = bus.a_req && bus.b_req;
            // prio=0 favours A, prio=1 favours B on a conflict
            a_gnt    = bus.a_req && (!bus.b_req || !prio);
            b_gnt    = bus.b_req && !a_gnt;
            if (a_gnt)
               prio_nx = 1'b1;
            else if (b_gnt)
               prio_nx = 1'b0;
         end
         default: state_nx = RST_STATE;
      endcase
   end

   always_comb begin
      bus.mem_wen   = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      unique case (1'b1)
         a_gnt: begin
            bus.mem_addr = bus.a_addr;
         end
         b_gnt: begin
            bus.mem_addr  = bus.b_addr;
            bus.mem_wen   = bus.b_wen;
            bus.mem_wdata = bus.b_wdata;
         end
         default: ;
      endcase
   end

   assign bus.a_gnt    = a_gnt;
   assign bus.b_gnt    = b_gnt;
   assign bus.a_rvalid = a_rv_q;
   assign bus.b_rvalid = b_rv_q;
   // Memory output already reflects last cycle's registered address.
   assign bus.a_rdata  = bus.mem_rdata;
   assign bus.b_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter against a transaction-level model
// of grants, priority, read returns and conflict statistics.
module tb_mem_port_arbiter;
   localparam int INIT_CYCLES = 2;
   localparam int CNT_W       = 4;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             ready;
   logic [CNT_W-1:0] conflict_cnt;

   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(
      .INIT_CYCLES(INIT_CYCLES),
      .CNT_W      (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .ready       (ready),
      .conflict_cnt(conflict_cnt)
   );

   // single-port memory with registered read address
   logic [15:0] mem [256];
   logic [15:0] mem_q_addr;
   always @(posedge clk) begin
      if (bus.mem_wen) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      mem_q_addr <= bus.mem_addr;
   end
   assign bus.mem_rdata = mem[mem_q_addr[7:0]];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model state
   logic [15:0] ref_mem [256];
   bit          mvalid = 1'b0;
   int          age = 0;
   bit          prio = 1'b0;
   bit          pend_a = 1'b0;
   bit          pend_b = 1'b0;
   logic [15:0] pend_a_addr, pend_b_addr;
   int          ccnt = 0;
   bit          ag_s, bg_s;

   task automatic cyc();
      bit          rdy, ea, eb, ar, br, bw, rs;
      logic [15:0] aa, ba, bd, eaddr;
      @(negedge clk);
      ar = bus.a_req;  aa = bus.a_addr;
      br = bus.b_req;  ba = bus.b_addr;
      bw = bus.b_wen;  bd = bus.b_wdata;
      rs = rst;
      rdy = mvalid && (age >= INIT_CYCLES + 1);
      ea = 1'b0;
      eb = 1'b0;
      if (rdy) begin
         if (ar && (!br || !prio)) ea = 1'b1;
         else if (br)              eb = 1'b1;
      end
      eaddr = ea ? aa : (eb ? ba : 16'h0);
      if (mvalid) begin
         chk("ready",    32'(ready),        32'(rdy));
         chk("a_gnt",    32'(bus.a_gnt),    32'(ea));
         chk("b_gnt",    32'(bus.b_gnt),    32'(eb));
         chk("mem_addr", 32'(bus.mem_addr), 32'(eaddr));
         chk("mem_wen",  32'(bus.mem_wen),  32'(eb && bw));
         if (eb && bw) chk("mem_wdata", 32'(bus.mem_wdata), 32'(bd));
         chk("a_rvalid", 32'(bus.a_rvalid), 32'(pend_a));
         chk("b_rvalid", 32'(bus.b_rvalid), 32'(pend_b));
         if (pend_a) chk("a_rdata", 32'(bus.a_rdata), 32'(ref_mem[pend_a_addr[7:0]]));
         if (pend_b) chk("b_rdata", 32'(bus.b_rdata), 32'(ref_mem[pend_b_addr[7:0]]));
         chk("conflict_cnt", 32'(conflict_cnt), 32'(ccnt));
      end
      ag_s = bus.a_gnt;
      bg_s = bus.b_gnt;
      @(posedge clk);
      if (eb && bw) ref_mem[ba[7:0]] = bd;
      if (rs) begin
         mvalid = 1'b1;
         age    = 1;
         prio   = 1'b0;
         pend_a = 1'b0;
         pend_b = 1'b0;
         ccnt   = 0;
      end else if (mvalid) begin
         pend_a      = ea;
         pend_a_addr = aa;
         pend_b      = eb && !bw;
         pend_b_addr = ba;
         if (ea) prio = 1'b1;
         if (eb) prio = 1'b0;
         if (rdy && ar && br && ccnt < CNT_MAX) ccnt++;
         if (age < 1000) age++;
      end
      #1;
   endtask

   // requesters hold their request until granted
   task automatic drive_rand(input int pa, input int pb, input int pw,
                             input int prst);
      if (!bus.a_req || ag_s) begin
         bus.a_req  = ($urandom_range(99) < pa);
         bus.a_addr = 16'($urandom_range(31));
      end
      if (!bus.b_req || bg_s) begin
         bus.b_req   = ($urandom_range(99) < pb);
         bus.b_wen   = ($urandom_range(99) < pw);
         bus.b_addr  = 16'($urandom_range(31));
         bus.b_wdata = 16'($urandom);
      end
      rst = (prst > 0) && ($urandom_range(999) < prst);
   endtask

   task automatic run(input int n, input int pa, input int pb,
                      input int pw, input int prst);
      repeat (n) begin
         cyc();
         drive_rand(pa, pb, pw, prst);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 16'hA000 ^ 16'(i * 7);
         ref_mem[i] = 16'hA000 ^ 16'(i * 7);
      end
      rst         = 1'b1;
      bus.a_req   = 1'b0;
      bus.a_addr  = '0;
      bus.b_req   = 1'b0;
      bus.b_wen   = 1'b0;
      bus.b_addr  = '0;
      bus.b_wdata = '0;
      cyc();
      cyc();

      // hold-off window with A waiting from the first cycle
      rst        = 1'b0;
      bus.a_req  = 1'b1;
      bus.a_addr = 16'h0007;
      run(5, 100, 0, 0, 0);

      // continuous dual reads after a fresh reset
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus.a_req = 1'b1;
      bus.b_req = 1'b1;
      bus.b_wen = 1'b0;
      run(INIT_CYCLES, 100, 100, 0, 0);
      run(6, 100, 100, 0, 0);
      chk("conflict_after_6", 32'(conflict_cnt), 32'(6));
      run(4, 0, 0, 0, 0);

      // B write then A read of the same word
      bus.b_req   = 1'b1;
      bus.b_wen   = 1'b1;
      bus.b_addr  = 16'h0010;
      bus.b_wdata = 16'h1234;
      cyc();
      bus.b_req  = 1'b0;
      bus.b_wen  = 1'b0;
      bus.a_req  = 1'b1;
      bus.a_addr = 16'h0010;
      cyc();
      bus.a_req = 1'b0;
      cyc();
      chk("raw_data", 32'(ref_mem[16]), 32'(16'h1234));
      cyc();

      // B alone for three cycles, then a conflict with prio back on A
      run(1, 0, 100, 0, 0);
      run(2, 0, 100, 0, 0);
      run(4, 100, 100, 0, 0);
      run(4, 0, 0, 0, 0);

      // reset lands on the edge of an A grant
      bus.a_req  = 1'b1;
      bus.a_addr = 16'h0005;
      bus.b_req  = 1'b0;
      rst        = 1'b1;
      cyc();
      rst = 1'b0;
      run(6, 100, 0, 0, 0);

      // saturate the conflict counter
      run(24, 100, 100, 50, 0);
      chk("conflict_sat", 32'(conflict_cnt), 32'(CNT_MAX));

      run(3000, 60, 60, 40, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
